// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one ALU between two requesters with a fixed-latency issue/capture sequence
module alu_req_arbiter #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [2:0]       REQ0_OP,
  input  logic [WIDTH-1:0] REQ0_X,
  input  logic [WIDTH-1:0] REQ0_Y,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [2:0]       REQ1_OP,
  input  logic [WIDTH-1:0] REQ1_X,
  input  logic [WIDTH-1:0] REQ1_Y,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic             RSP_ID,
  output logic [WIDTH-1:0] RSP_RES,
  output logic             RSP_CF,
  output logic             ALU_EN,
  output logic [2:0]       ALU_OP,
  output logic [WIDTH-1:0] ALU_X,
  output logic [WIDTH-1:0] ALU_Y,
  input  logic [WIDTH-1:0] ALU_RES,
  input  logic             ALU_CF,
  output logic             BUSY
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic             cf_q, cf_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
  logic             gnt1, acc;
  logic [2:0]       req_op;
  // last_q holds the most recent grant; requester 1 loses a tie after reset
  assign gnt1       = REQ1_VALID & (~REQ0_VALID | ~last_q);
  assign REQ0_READY = (state_q == IDLE) & REQ0_VALID & ~gnt1;
  assign REQ1_READY = (state_q == IDLE) & gnt1;
  assign acc        = REQ0_READY | REQ1_READY;
  assign req_op     = gnt1 ? REQ1_OP : REQ0_OP;
  assign ALU_EN     = state_q == ISSUE;
  assign ALU_OP     = op_q;
  assign ALU_X      = x_q;
  assign ALU_Y      = y_q;
  assign RSP_VALID  = state_q == RESP;
  assign RSP_ID     = id_q;
  assign RSP_RES    = res_q;
  assign RSP_CF     = cf_q;
  assign BUSY       = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    cf_d    = cf_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (acc) begin
        op_d    = req_op;
        x_d     = gnt1 ? REQ1_X : REQ0_X;
        y_d     = gnt1 ? REQ1_Y : REQ0_Y;
        id_d    = gnt1;
        last_d  = gnt1;
        state_d = (req_op == 3'b000) ? RESP : ISSUE;
        res_d   = (req_op == 3'b000) ? '0 : res_q;
        cf_d    = (req_op == 3'b000) ? 1'b0 : cf_q;
      end
      ISSUE: begin
        cnt_d   = 3'(ALU_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 3'd1;
        state_d = (cnt_q == 3'd1) ? RESP : WAIT;
        res_d   = (cnt_q == 3'd1) ? ALU_RES : res_q;
        cf_d    = (cnt_q == 3'd1) ? ALU_CF : cf_q;
      end
      RESP: state_d = RSP_READY ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      cf_q    <= 1'b0;
      op_q    <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      cf_q    <= cf_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: transaction-level model of the arbiter plus directed scenarios
module tb_alu_req_arbiter;
  localparam int W     = 16;
  localparam int ALU_L = 1;
  logic CLK = 0, RST_N = 0;
  logic REQ0_VALID = 0, REQ1_VALID = 0, RSP_READY = 1;
  logic [2:0] REQ0_OP = 0, REQ1_OP = 0;
  logic [W-1:0] REQ0_X = 0, REQ0_Y = 0, REQ1_X = 0, REQ1_Y = 0;
  logic REQ0_READY, REQ1_READY, RSP_VALID, RSP_ID, RSP_CF, ALU_EN, ALU_CF, BUSY;
  logic [2:0] ALU_OP;
  logic [W-1:0] RSP_RES, ALU_X, ALU_Y, ALU_RES;
  logic d3_REQ0_READY, d3_REQ1_READY, d3_RSP_VALID, d3_RSP_ID, d3_RSP_CF, d3_ALU_EN, d3_ALU_CF, d3_BUSY;
  logic [2:0] d3_ALU_OP;
  logic [W-1:0] d3_RSP_RES, d3_ALU_X, d3_ALU_Y, d3_ALU_RES;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  alu_req_arbiter #(.WIDTH(W), .ALU_LAT(ALU_L)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OP(REQ0_OP), .REQ0_X(REQ0_X), .REQ0_Y(REQ0_Y),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OP(REQ1_OP), .REQ1_X(REQ1_X), .REQ1_Y(REQ1_Y),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID), .RSP_RES(RSP_RES), .RSP_CF(RSP_CF),
    .ALU_EN(ALU_EN), .ALU_OP(ALU_OP), .ALU_X(ALU_X), .ALU_Y(ALU_Y), .ALU_RES(ALU_RES), .ALU_CF(ALU_CF),
    .BUSY(BUSY));
  alu_req_arbiter #(.WIDTH(W), .ALU_LAT(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(d3_REQ0_READY), .REQ0_OP(REQ0_OP), .REQ0_X(REQ0_X), .REQ0_Y(REQ0_Y),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(d3_REQ1_READY), .REQ1_OP(REQ1_OP), .REQ1_X(REQ1_X), .REQ1_Y(REQ1_Y),
    .RSP_VALID(d3_RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(d3_RSP_ID), .RSP_RES(d3_RSP_RES), .RSP_CF(d3_RSP_CF),
    .ALU_EN(d3_ALU_EN), .ALU_OP(d3_ALU_OP), .ALU_X(d3_ALU_X), .ALU_Y(d3_ALU_Y), .ALU_RES(d3_ALU_RES), .ALU_CF(d3_ALU_CF),
    .BUSY(d3_BUSY));
  function automatic logic [16:0] alu_f(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    case (op)
      3'd1, 3'd5: return {1'b0, x} + {1'b0, y};
      3'd2, 3'd6: return {1'b0, x & y};
      3'd3, 3'd7: return {1'b0, x | y};
      3'd4: return (x < y) ? 17'h10001 : 17'h00000;
      default: return 17'h0;
    endcase
  endfunction
  logic [16:0] alu1 = '0;
  logic [16:0] p3 [3] = '{default: '0};
  always @(posedge CLK) if (ALU_EN) alu1 <= alu_f(ALU_OP, ALU_X, ALU_Y);
  assign {ALU_CF, ALU_RES} = alu1;
  always @(posedge CLK) begin
    if (d3_ALU_EN) p3[0] <= alu_f(d3_ALU_OP, d3_ALU_X, d3_ALU_Y);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign {d3_ALU_CF, d3_ALU_RES} = p3[2];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: handshake did not occur within the cycle budget at %0t", nm, $time);
  endtask
  // Model: one transaction at a time, timed by cycles since acceptance
  bit m_busy = 0, m_nop = 0, m_id = 0, m_last = 1, m_cf = 0, run = 0;
  int m_age = 0;
  logic [2:0] m_op = 0;
  logic [15:0] m_x = 0, m_y = 0, m_res = 0;
  logic hs_id[$];
  logic [15:0] hs_res[$];
  always @(negedge CLK) begin : cmp
    bit idle, g, any, er, ee;
    if (run) begin
      idle = !m_busy;
      any  = REQ0_VALID || REQ1_VALID;
      g    = (REQ0_VALID && REQ1_VALID) ? !m_last : REQ1_VALID;
      er   = m_busy && (m_nop ? m_age >= 1 : m_age >= ALU_L + 2);
      ee   = m_busy && !m_nop && m_age == 1;
      chk("ready0", REQ0_READY, idle && any && !g);
      chk("ready1", REQ1_READY, idle && any && g);
      chk("busy", BUSY, m_busy);
      chk("alu_en", ALU_EN, ee);
      chk("rsp_valid", RSP_VALID, er);
      if (er) begin
        chk("rsp_id", RSP_ID, m_id);
        chk("rsp_res", RSP_RES, m_res);
        chk("rsp_cf", RSP_CF, m_cf);
        if (RSP_READY) begin
          hs_id.push_back(RSP_ID);
          hs_res.push_back(RSP_RES);
        end
      end
      if (ee) begin
        chk("alu_op", ALU_OP, m_op);
        chk("alu_x", ALU_X, m_x);
        chk("alu_y", ALU_Y, m_y);
      end
      if (!RST_N) begin
        m_busy = 0;
        m_last = 1;
      end else if (idle && any) begin
        m_busy = 1;
        m_age  = 1;
        m_id   = g;
        m_last = g;
        m_op   = g ? REQ1_OP : REQ0_OP;
        m_x    = g ? REQ1_X : REQ0_X;
        m_y    = g ? REQ1_Y : REQ0_Y;
        m_nop  = m_op == 3'd0;
        {m_cf, m_res} = alu_f(m_op, m_x, m_y);
      end else if (er && RSP_READY) m_busy = 0;
      else if (m_busy) m_age++;
    end
  end
  bit mon3 = 0, d3_seen = 0;
  always @(negedge CLK) if (mon3 && d3_RSP_VALID) d3_seen = 1;
  task automatic send(input bit id, input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    bit ok = 0;
    if (id) begin REQ1_OP = op; REQ1_X = x; REQ1_Y = y; REQ1_VALID = 1; end
    else begin REQ0_OP = op; REQ0_X = x; REQ0_Y = y; REQ0_VALID = 1; end
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge CLK);
      ok = id ? REQ1_READY : REQ0_READY;
    end
    if (!ok) tmo("send");
    @(posedge CLK); #1;
    if (id) REQ1_VALID = 0; else REQ0_VALID = 0;
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge CLK);
      ok = !BUSY;
    end
    if (!ok) tmo("wait_idle");
    @(posedge CLK); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    @(posedge CLK); #1 run = 1;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1;
    repeat (3) begin
      @(negedge CLK);
      chk("idle_outs", {BUSY, ALU_EN, RSP_VALID, REQ0_READY, REQ1_READY, RSP_ID, RSP_CF}, 0);
      chk("idle_alu_x", ALU_X, 0);
    end
    hs_id.delete(); hs_res.delete();
    @(posedge CLK); #1;
    REQ0_OP = 3'd2; REQ0_X = 16'h00F0; REQ0_Y = 16'h0FF0;
    REQ1_OP = 3'd2; REQ1_X = 16'h00F0; REQ1_Y = 16'h0FF0;
    REQ0_VALID = 1; REQ1_VALID = 1;
    for (int n = 0; n < 100 && hs_id.size() < 4; n++) @(negedge CLK);
    @(posedge CLK); #1;
    REQ0_VALID = 0; REQ1_VALID = 0;
    if (hs_id.size() < 4) tmo("contention");
    else for (int i = 0; i < 4; i++) begin
      chk("fair_id", hs_id[i], i % 2);
      chk("fair_res", hs_res[i], 16'h00F0);
    end
    wait_idle();
    send(0, 3'd1, 16'hFFFF, 16'h0001);
    @(negedge CLK);
    chk("add_en_t1", ALU_EN, 1);
    chk("add_rspv_t1", RSP_VALID, 0);
    @(negedge CLK);
    chk("add_en_t2", ALU_EN, 0);
    chk("add_rspv_t2", RSP_VALID, 0);
    @(negedge CLK);
    chk("add_rspv_t3", RSP_VALID, 1);
    chk("add_id", RSP_ID, 0);
    chk("add_res", RSP_RES, 16'h0000);
    chk("add_cf", RSP_CF, 1);
    wait_idle();
    RSP_READY = 0;
    send(1, 3'd4, 16'd3, 16'd5);
    REQ0_OP = 3'd3; REQ0_X = 16'd1; REQ0_Y = 16'd2; REQ0_VALID = 1;
    begin : wr
      bit ok = 0;
      for (int n = 0; n < 20 && !ok; n++) begin
        @(negedge CLK);
        ok = RSP_VALID;
      end
      if (!ok) tmo("bp_rsp");
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", RSP_VALID, 1);
      chk("bp_res", RSP_RES, 1);
      chk("bp_cf", RSP_CF, 1);
      chk("bp_id", RSP_ID, 1);
      chk("bp_ready0", REQ0_READY, 0);
      @(negedge CLK);
    end
    @(posedge CLK); #1 RSP_READY = 1;
    send(0, 3'd3, 16'd1, 16'd2);
    wait_idle();
    send(0, 3'd0, 16'hABCD, 16'h1234);
    @(negedge CLK);
    chk("nop_rspv", RSP_VALID, 1);
    chk("nop_res", RSP_RES, 0);
    chk("nop_cf", RSP_CF, 0);
    chk("nop_en", ALU_EN, 0);
    wait_idle();
    RST_N = 0;
    @(posedge CLK); #1 RST_N = 1;
    mon3 = 1;
    send(0, 3'd1, 16'h1234, 16'h0001);
    @(negedge CLK);
    chk("d3_en_t1", d3_ALU_EN, 1);
    @(negedge CLK);
    chk("d3_wait", {d3_BUSY, d3_ALU_EN, d3_RSP_VALID}, 3'b100);
    @(posedge CLK); #1 RST_N = 0;
    @(posedge CLK); #1;
    @(posedge CLK); #1 RST_N = 1;
    @(negedge CLK);
    chk("d3_rst_outs", {d3_BUSY, d3_ALU_EN, d3_RSP_VALID, d3_RSP_ID, d3_RSP_CF, d3_REQ0_READY, d3_REQ1_READY, d3_ALU_OP}, 0);
    chk("d3_rst_res", d3_RSP_RES, 0);
    chk("d3_rst_x", d3_ALU_X, 0);
    mon3 = 0;
    chk("d3_no_rsp", d3_seen, 0);
    @(posedge CLK); #1;
    REQ0_OP = 3'd1; REQ0_X = 16'd7; REQ0_Y = 16'd8;
    REQ1_OP = 3'd1; REQ1_X = 16'd9; REQ1_Y = 16'd1;
    REQ0_VALID = 1; REQ1_VALID = 1;
    @(negedge CLK);
    chk("d3_first_gnt0", d3_REQ0_READY, 1);
    chk("d3_first_gnt1", d3_REQ1_READY, 0);
    @(posedge CLK); #1 REQ0_VALID = 0;
    send(1, 3'd1, 16'd9, 16'd1);
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
